// File: rtl/ktane_pkg.sv
// Shared types and constants for the bomb clock blocks.
package ktane_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_RUN,
      ST_PAUSE,
      ST_EXPIRED
   } state_t;

   localparam int BCD_W            = 4;
   localparam int MAX_SEC_TENS     = 5;
   localparam int MAX_STRIKE_SHIFT = 2;

   function automatic logic [BCD_W-1:0] bcd_clamp(input logic [BCD_W-1:0] v,
                                                  input logic [BCD_W-1:0] max_v);
      return (v > max_v) ? max_v : v;
   endfunction

endpackage

// File: rtl/bcd_digit_down.sv
// One BCD down-counting digit with programmable modulus, borrow chaining and clamped load.
module bcd_digit_down
   import ktane_pkg::*;
(
   input  logic             clk,
   input  logic             reset_n,
   input  logic             load,
   input  logic [BCD_W-1:0] load_val,
   input  logic [BCD_W-1:0] modulus,
   input  logic             borrow_in,
   output logic [BCD_W-1:0] dig,
   output logic             borrow_out
);

   localparam logic [BCD_W-1:0] ONE = BCD_W'(1);

   logic [BCD_W-1:0] dig_d, dig_q;
   logic [BCD_W-1:0] max_v;

   assign max_v      = modulus - ONE;
   assign borrow_out = borrow_in && (dig_q == '0);
   assign dig        = dig_q;

   // borrow_in doubles as "decrement this digit now"
   always_comb begin
      dig_d = dig_q;
      if (load)
         dig_d = bcd_clamp(load_val, max_v);
      else if (borrow_in)
         dig_d = (dig_q == '0) ? max_v : dig_q - ONE;
   end

   always_ff @(posedge clk) begin
      if (!reset_n)
         dig_q <= '0;
      else
         dig_q <= dig_d;
   end

endmodule

// File: rtl/bomb_countdown_bcd.sv
// MM:SS BCD countdown with start/pause, strike-accelerated tick rate and expiry flag.
module bomb_countdown_bcd
   import ktane_pkg::*;
#(
   parameter int TICK_CYCLES = 50000000
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       load,
   input  logic [3:0] load_mt,
   input  logic [3:0] load_mu,
   input  logic [3:0] load_st,
   input  logic [3:0] load_su,
   input  logic       start,
   input  logic       pause,
   input  logic [1:0] strikes,
   output logic [3:0] dig_mt,
   output logic [3:0] dig_mu,
   output logic [3:0] dig_st,
   output logic [3:0] dig_su,
   output logic       running,
   output logic       tick,
   output logic       expired
);

   localparam int            PW      = (TICK_CYCLES > 2) ? $clog2(TICK_CYCLES) : 2;
   localparam logic [PW:0]   TC      = (PW+1)'(TICK_CYCLES);
   localparam logic [PW:0]   ONE_W   = (PW+1)'(1);
   localparam logic [PW-1:0] ONE_P   = PW'(1);
   localparam logic [1:0]    MAX_SH  = 2'(MAX_STRIKE_SHIFT);
   localparam logic [BCD_W-1:0] MOD10 = BCD_W'(10);
   localparam logic [BCD_W-1:0] MOD6  = BCD_W'(MAX_SEC_TENS + 1);

   state_t        state_d, state_q;
   logic [PW-1:0] presc_d, presc_q;
   logic          tick_d, tick_q;
   logic          dec;
   logic [1:0]    shift;
   logic [PW:0]   period_m1;
   logic          is_zero, is_one;
   logic          b_su, b_st, b_mu, mt_borrow_unused;

   assign shift     = (strikes > MAX_SH) ? MAX_SH : strikes;
   assign period_m1 = (TC >> shift) - ONE_W;
   assign is_zero   = ({dig_mt, dig_mu, dig_st, dig_su} == 16'h0000);
   assign is_one    = ({dig_mt, dig_mu, dig_st, dig_su} == 16'h0001);

   always_comb begin
      state_d = state_q;
      presc_d = presc_q;
      tick_d  = 1'b0;
      dec     = 1'b0;
      if (load) begin
         state_d = ST_IDLE;
         presc_d = '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (!pause && start) begin
                  state_d = is_zero ? ST_EXPIRED : ST_RUN;
                  presc_d = '0;
               end
            end
            ST_RUN: begin
               if (pause) begin
                  state_d = ST_PAUSE;
               end else if ({1'b0, presc_q} >= period_m1) begin
                  // >= so a strike arriving mid-period fires on the next cycle
                  presc_d = '0;
                  tick_d  = 1'b1;
                  dec     = 1'b1;
                  if (is_one)
                     state_d = ST_EXPIRED;
               end else begin
                  presc_d = presc_q + ONE_P;
               end
            end
            ST_PAUSE: begin
               if (!pause && start)
                  state_d = ST_RUN;
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q <= ST_IDLE;
         presc_q <= '0;
         tick_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         presc_q <= presc_d;
         tick_q  <= tick_d;
      end
   end

   assign running = (state_q == ST_RUN);
   assign expired = (state_q == ST_EXPIRED);
   assign tick    = tick_q;

   bcd_digit_down u_su (
      .clk(clk), .reset_n(reset_n), .load(load), .load_val(load_su),
      .modulus(MOD10), .borrow_in(dec), .dig(dig_su), .borrow_out(b_su)
   );
   bcd_digit_down u_st (
      .clk(clk), .reset_n(reset_n), .load(load), .load_val(load_st),
      .modulus(MOD6), .borrow_in(b_su), .dig(dig_st), .borrow_out(b_st)
   );
   bcd_digit_down u_mu (
      .clk(clk), .reset_n(reset_n), .load(load), .load_val(load_mu),
      .modulus(MOD10), .borrow_in(b_st), .dig(dig_mu), .borrow_out(b_mu)
   );
   bcd_digit_down u_mt (
      .clk(clk), .reset_n(reset_n), .load(load), .load_val(load_mt),
      .modulus(MOD10), .borrow_in(b_mu), .dig(dig_mt), .borrow_out(mt_borrow_unused)
   );

endmodule
